// File: rtl/bcd_timer.sv
// bcd_timer: chained two-digit BCD up/down timer with run/pause/done control.
// Pair 0 is least significant; the top pair counts 0..TOP_MAX.
module bcd_timer #(
  parameter int NUM_PAIRS = 3,
  parameter int TOP_MAX   = 99,
  parameter int LED_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   load,
  input  logic                   mode,
  input  logic                   start,
  input  logic                   pause,
  input  logic [8*NUM_PAIRS-1:0] init_value,
  output logic [8*NUM_PAIRS-1:0] digits,
  output logic                   running,
  output logic                   expired,
  output logic                   expire_pulse,
  output logic [LED_WIDTH-1:0]   led
);

  localparam int W = 8 * NUM_PAIRS;
  localparam logic [7:0] TOP_BIN = 8'(TOP_MAX);
  localparam logic [3:0] TOP_T = 4'(TOP_MAX / 10);
  localparam logic [3:0] TOP_U = 4'(TOP_MAX % 10);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [W-1:0] count;
  logic [W-1:0] target;
  logic         mode_q;
  logic [W-1:0] clamped;
  logic [W-1:0] stepped;

  function automatic logic [W-1:0] clamp_bcd(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic [3:0]   t;
    logic [3:0]   u;
    logic [7:0]   val;
    r = '0;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      t = v[8*k+4 +: 4];
      u = v[8*k +: 4];
      if (u > 4'd9) u = 4'd9;
      if (k == NUM_PAIRS - 1) begin
        val = 8'(t) * 8'd10 + 8'(u);
        if (val > TOP_BIN) begin
          t = TOP_T;
          u = TOP_U;
        end
      end else if (t > 4'd5) begin
        t = 4'd5;
      end
      r[8*k +: 8] = {t, u};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] dec_bcd(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic [3:0]   t;
    logic [3:0]   u;
    logic         b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      t = v[8*k+4 +: 4];
      u = v[8*k +: 4];
      if (b) begin
        if (u != 4'd0) begin
          u = u - 4'd1;
          b = 1'b0;
        end else begin
          u = 4'd9;
          if (t != 4'd0) begin
            t = t - 4'd1;
            b = 1'b0;
          end else begin
            t = (k == NUM_PAIRS - 1) ? 4'd9 : 4'd5;
          end
        end
      end
      r[8*k +: 8] = {t, u};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] inc_bcd(
    input logic [W-1:0] v
  );
    logic [W-1:0] r;
    logic [3:0]   t;
    logic [3:0]   u;
    logic         c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < NUM_PAIRS; k++) begin
      t = v[8*k+4 +: 4];
      u = v[8*k +: 4];
      if (c) begin
        if (u != 4'd9) begin
          u = u + 4'd1;
          c = 1'b0;
        end else begin
          u = 4'd0;
          if (k == NUM_PAIRS - 1) begin
            t = t + 4'd1;
            c = 1'b0;
          end else if (t != 4'd5) begin
            t = t + 4'd1;
            c = 1'b0;
          end else begin
            t = 4'd0;
          end
        end
      end
      r[8*k +: 8] = {t, u};
    end
    return r;
  endfunction

  // Preset clamping and the next count for one step in the latched direction
  always_comb begin
    clamped = clamp_bcd(init_value);
    stepped = mode_q ? inc_bcd(count) : dec_bcd(count);
  end

  // Control FSM, count/target registers, expiry strobe and led flasher
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      target       <= '0;
      mode_q       <= 1'b0;
      expire_pulse <= 1'b0;
      led          <= '0;
    end else begin
      expire_pulse <= 1'b0;
      if (load) begin
        mode_q <= mode;
        if (mode) begin
          count  <= '0;
          target <= clamped;
        end else begin
          count  <= clamped;
          target <= '0;
        end
        state <= IDLE;
        led   <= '0;
      end else if (start) begin
        if ((state == IDLE || state == PAUSE)
            && count != target)
          state <= RUN;
      end else if (pause) begin
        if (state == RUN) state <= PAUSE;
      end else if (tick) begin
        if (state == RUN && count != target) begin
          count <= stepped;
          if (stepped == target) begin
            state        <= DONE;
            expire_pulse <= 1'b1;
            led          <= '1;
          end
        end else if (state == DONE) begin
          led <= ~led;
        end
      end
    end
  end

  assign digits  = count;
  assign running = (state == RUN);
  assign expired = (state == DONE);

endmodule

// File: doc/bcd_timer.md
# bcd_timer

Parametrised BCD countdown/countup timer for the digital-watch datapath: NUM_PAIRS two-digit BCD fields (default HH:MM:SS) chained with borrow/carry. It is the next generation of the fixed six-digit down counter: generalised field count, selectable direction, explicit run/pause/done state machine, input clamping and a one-cycle expiry strobe. It sits between the 1 Hz tick generator / keypad controller and the 7-segment scan driver and LED bank.

## Interface
- NUM_PAIRS, 3, number of two-digit BCD fields; pair 0 is least significant (seconds); range 1..4
- TOP_MAX, 99, maximum value of the most significant pair, integer 1..99 (e.g. 23 for hours)
- LED_WIDTH, 6, width of the led output

- clk  in  1  global clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle count strobe (1 Hz from prescaler)
- load  in  1  load init_value and mode; forces IDLE
- mode  in  1  0 = count down to zero, 1 = count up from zero to init_value; sampled only on load
- start  in  1  start/resume
- pause  in  1  pause
- init_value  in  8*NUM_PAIRS  BCD preset/target, pair k at [8k+7:8k], tens in upper nibble
- digits  out  8*NUM_PAIRS  current count, same packing
- running  out  1  high in RUN
- expired  out  1  high in DONE
- expire_pulse  out  1  one-cycle strobe on entry to DONE
- led  out  LED_WIDTH  all-ones/all-zeros flash in DONE, else zero

## Operation
- States: IDLE, RUN, PAUSE, DONE. Registers: count, target, mode_q, led phase.
- Reset: state IDLE, count 0, target 0, mode_q 0, all outputs 0.
- Command priority: load > start > pause > tick.
- load (any state): clamp init_value; mode_q=mode; down: count=clamped, target=0; up: count=0, target=clamped; state IDLE.
- Clamp per pair: units >9 -> 9; tens of pairs below top >5 -> 5; top pair value >TOP_MAX -> TOP_MAX (after unit clamp).
- start in IDLE/PAUSE: RUN if count != target; ignored if count == target. start in RUN/DONE ignored.
- pause in RUN -> PAUSE; elsewhere ignored.
- tick in RUN (no load/start/pause same cycle): count steps one.
  - Down: units 0 -> 9 with borrow; tens of non-top pairs 0 -> 5 with borrow; top pair decrements as 0..TOP_MAX; never underflows (terminal stop at 0).
  - Up: units 9 -> 0 with carry; non-top tens 5 -> 0 with carry; top pair increments; never exceeds target.
- If the stepped count == target: state DONE same edge, expire_pulse for the next cycle only.
- DONE: count holds; led toggles between all-ones and all-zeros on each tick, first value all-ones on entry; left only by load or rst.
- tick in IDLE/PAUSE/DONE-count: no count change.

## Timing
- All outputs registered; digits reflect a tick one cycle after the tick edge (latency 1).
- load -> digits valid on the following cycle; running low same cycle.
- expire_pulse exactly one clk cycle wide, asserted in the cycle after the terminal-count edge, simultaneous with expired rising.
- tick and pause in the same RUN cycle: pause wins, no decrement.
- tick and load same cycle: load wins, no step from loaded value.
- rst mid-run: immediate asynchronous clear, no expire_pulse.
- Back-to-back ticks on consecutive cycles must each step (no tick spacing assumed).

## Test plan
- Down basic: load 00:01:00 mode 0, start, 60 ticks -> 00:00:59 after tick 1, 00:00:00 after tick 60, expire_pulse one cycle, expired=1, led=6'b111111 then 000000 on next tick.
- Borrow chain: load 01:00:00, start, 1 tick -> 00:59:59; NUM_PAIRS=2 build load 10:00, 1 tick -> 09:59.
- Up mode: load 00:00:12 mode 1 -> digits 00:00:00; start, 12 ticks -> 00:00:09 then 00:00:10, expire at 00:00:12.
- Pause/priority: in RUN at 00:00:30 assert pause+tick -> 00:00:30 held, running=0; start -> resumes; load+tick same cycle -> loaded value unchanged.
- Clamp/edge: TOP_MAX=23, load 0x9F:0x7A:0x59 -> 23:59:59; load 00:00:00 down, start -> stays IDLE, no expire_pulse.
- Reset mid-run: rst during RUN at 00:10:05 -> digits 0, state IDLE, all outputs 0 asynchronously, no strobe.
